int_resp: RTL and testbench

//  Core-side responder for the interrupt controller's int_vld/int_rdy handshake.
//  - Accepts an interrupt request and waits for an instruction boundary.
//  - Saves the return PC to EPC and redirects the core to the ISR vector.
//  - Blocks further requests until the core retires RETI, then redirects back to EPC.
//  - Sits between the interrupt controller and the core fetch stage; the data bus reaches it through the local decode.

---
 rtl/int_resp.sv | 142 ++++++++++++++
 tb/tb_int_resp.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_resp.sv
// int_resp: core-side responder for the int_vld/int_rdy handshake; redirects fetch to IVEC on
// entry and back to EPC on RETI. Define INT_RESP_NEST_EN for a 4-deep nested EPC stack.
module int_resp #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] addr,
    input  logic          we,
    output logic [DW-1:0] dout,
    input  logic          int_vld,
    output logic          int_rdy,
    input  logic          ins_bnd,
    input  logic [AW-1:0] pc_i,
    input  logic          reti,
    output logic          pc_jmp,
    output logic [AW-1:0] pc_tgt,
    output logic          in_isr
);
    typedef enum logic [1:0] {StIdle, StWait, StActive} state_e;
    state_e state_q, state_d;

    logic [AW-1:0] ivec_q, epc_rd, ret_tgt, pc_tgt_q;
    logic [DW-1:0] dout_q, rdata;
    logic          ien_q, pc_jmp_q, act, pend, room, last_ret;
    logic [7:0]    depth;
    logic          accept, enter, leave;
    logic          sel_ivec, sel_epc, sel_stat;
    logic          unused_din;

    assign sel_ivec   = addr == AW'(0);
    assign sel_epc    = addr == AW'(1);
    assign sel_stat   = addr == AW'(2);
    assign unused_din = ^din[DW-1:AW];

    assign accept = int_vld && int_rdy;
    assign enter  = (state_q == StWait) && ins_bnd;
    assign leave  = (state_q == StActive) && reti;
    assign pend   = state_q == StWait;

`ifdef INT_RESP_NEST_EN
    logic [AW-1:0] stack_q [4];
    logic [2:0]    depth_q;
    logic [1:0]    top;

    assign top      = (depth_q == 3'd0) ? 2'd0 : 2'(depth_q - 3'd1);
    assign epc_rd   = stack_q[top];
    assign ret_tgt  = stack_q[top];
    assign act      = depth_q != 3'd0;
    assign depth    = {5'd0, depth_q};
    assign room     = depth_q < 3'd4;
    assign last_ret = depth_q == 3'd1;

    // Entry pushes at depth_q; a bus write hits the current top, so capture wins on overlap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= 3'd0;
            for (int i = 0; i < 4; i++) stack_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (enter && depth_q[1:0] == 2'(i)) stack_q[i] <= pc_i;
                else if (we && sel_epc && top == 2'(i)) stack_q[i] <= din[AW-1:0];
            end
            if (enter) depth_q <= depth_q + 3'd1;
            else if (leave) depth_q <= depth_q - 3'd1;
        end
    end
`else
    logic [AW-1:0] epc_q;

    assign epc_rd   = epc_q;
    assign ret_tgt  = epc_q;
    assign act      = state_q == StActive;
    assign depth    = {7'd0, act};
    assign room     = 1'b0;
    assign last_ret = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) epc_q <= '0;
        else if (enter) epc_q <= pc_i;
        else if (we && sel_epc) epc_q <= din[AW-1:0];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StWait;
            StWait:   if (ins_bnd) state_d = StActive;
            StActive: begin
                if (accept) state_d = StWait;
                else if (leave && last_ret) state_d = StIdle;
            end
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        int_rdy = 1'b0;
        unique case (state_q)
            StIdle:   int_rdy = ien_q;
            StActive: int_rdy = ien_q && room;
            default:  int_rdy = 1'b0;
        endcase
        in_isr = act;
    end

    always_comb begin
        rdata = '0;
        if (sel_ivec) rdata = DW'(ivec_q);
        else if (sel_epc) rdata = DW'(epc_rd);
        else if (sel_stat) rdata = DW'({depth, 5'd0, act, pend, ien_q});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ivec_q   <= '0;
            ien_q    <= 1'b0;
            dout_q   <= '0;
            pc_jmp_q <= 1'b0;
            pc_tgt_q <= '0;
        end else begin
            if (we && sel_ivec) ivec_q <= din[AW-1:0];
            if (we && sel_stat) ien_q <= din[0];
            if (!we) dout_q <= rdata;
            pc_jmp_q <= enter || leave;
            if (enter) pc_tgt_q <= ivec_q;
            else if (leave) pc_tgt_q <= ret_tgt;
        end
    end

    assign dout   = dout_q;
    assign pc_jmp = pc_jmp_q;
    assign pc_tgt = pc_tgt_q;
endmodule

// File: tb/tb_int_resp.sv
// Self-checking bench for int_resp: expected redirect targets and bus reads are queued as
// stimulus is driven and popped when the DUT produces them.
module tb_int_resp;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] dout;
    logic          int_vld;
    logic          int_rdy;
    logic          ins_bnd;
    logic [AW-1:0] pc_i;
    logic          reti;
    logic          pc_jmp;
    logic [AW-1:0] pc_tgt;
    logic          in_isr;

    int vectors = 0;
    int errors  = 0;
    int jmp_cnt = 0;
    logic [AW-1:0] exp_tgt[$];
    logic [DW-1:0] exp_rd[$];

    int_resp #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .din(din), .addr(addr), .we(we), .dout(dout),
        .int_vld(int_vld), .int_rdy(int_rdy), .ins_bnd(ins_bnd), .pc_i(pc_i),
        .reti(reti), .pc_jmp(pc_jmp), .pc_tgt(pc_tgt), .in_isr(in_isr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (pc_jmp === 1'b1) jmp_cnt++;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr = a; din = d; we = 1'b1;
        step();
        we = 1'b0; din = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
        addr = a; we = 1'b0;
        step();
        d = dout;
    endtask

    task automatic test_reset();
        logic [DW-1:0] d, e;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        vectors++; if (dout !== '0) begin errors++; $display("FAIL rst_dout: got %h want 0", dout); end
        vectors++; if (pc_jmp !== 1'b0) begin errors++; $display("FAIL rst_jmp: got %b want 0", pc_jmp); end
        vectors++; if (pc_tgt !== '0) begin errors++; $display("FAIL rst_tgt: got %h want 0", pc_tgt); end
        vectors++; if (in_isr !== 1'b0) begin errors++; $display("FAIL rst_isr: got %b want 0", in_isr); end
        vectors++; if (int_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %b want 0", int_rdy); end
        exp_rd.push_back(16'h0000);
        rd(13'h2, d); e = exp_rd.pop_front();
        vectors++; if (d !== e) begin errors++; $display("FAIL rst_stat: got %h want %h", d, e); end
    endtask

    task automatic test_entry_exit();
        logic [DW-1:0] d, e;
        logic [AW-1:0] t;
        wr(13'h0, 16'h0100);
        wr(13'h2, 16'h0001);
        vectors++; if (int_rdy !== 1'b1) begin errors++; $display("FAIL ee_rdy_idle: got %b want 1", int_rdy); end
        int_vld = 1'b1; pc_i = 13'h0042; ins_bnd = 1'b0;
        step();
        int_vld = 1'b0;
        vectors++; if (int_rdy !== 1'b0) begin errors++; $display("FAIL ee_rdy_wait: got %b want 0", int_rdy); end
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++; if (pc_jmp !== 1'b0) begin errors++; $display("FAIL ee_early_jmp: got %b want 0", pc_jmp); end
        end
        ins_bnd = 1'b1; exp_tgt.push_back(13'h0100);
        step();
        ins_bnd = 1'b0;
        t = exp_tgt.pop_front();
        vectors++; if (pc_jmp !== 1'b1) begin errors++; $display("FAIL ee_entry_jmp: got %b want 1", pc_jmp); end
        vectors++; if (pc_tgt !== t) begin errors++; $display("FAIL ee_entry_tgt: got %h want %h", pc_tgt, t); end
        vectors++; if (in_isr !== 1'b1) begin errors++; $display("FAIL ee_isr: got %b want 1", in_isr); end
        step();
        vectors++; if (pc_jmp !== 1'b0) begin errors++; $display("FAIL ee_jmp_width: got %b want 0", pc_jmp); end
        exp_rd.push_back(16'h0042);
        rd(13'h1, d); e = exp_rd.pop_front();
        vectors++; if (d !== e) begin errors++; $display("FAIL ee_epc: got %h want %h", d, e); end
        reti = 1'b1; exp_tgt.push_back(13'h0042);
        step();
        reti = 1'b0;
        t = exp_tgt.pop_front();
        vectors++; if (pc_jmp !== 1'b1) begin errors++; $display("FAIL ee_ret_jmp: got %b want 1", pc_jmp); end
        vectors++; if (pc_tgt !== t) begin errors++; $display("FAIL ee_ret_tgt: got %h want %h", pc_tgt, t); end
        vectors++; if (in_isr !== 1'b0) begin errors++; $display("FAIL ee_ret_isr: got %b want 0", in_isr); end
        vectors++; if (int_rdy !== 1'b1) begin errors++; $display("FAIL ee_ret_rdy: got %b want 1", int_rdy); end
    endtask

    task automatic test_blocking();
        int j0;
        logic [AW-1:0] t;
`ifndef INT_RESP_NEST_EN
        j0 = jmp_cnt;
        int_vld = 1'b1; ins_bnd = 1'b1; pc_i = 13'h0077;
        exp_tgt.push_back(13'h0100); exp_tgt.push_back(13'h0077);
        step(); step();
        t = exp_tgt.pop_front();
        vectors++; if (pc_tgt !== t) begin errors++; $display("FAIL blk_entry_tgt: got %h want %h", pc_tgt, t); end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++; if (int_rdy !== 1'b0) begin errors++; $display("FAIL blk_rdy: got %b want 0", int_rdy); end
        end
        reti = 1'b1;
        step();
        reti = 1'b0; int_vld = 1'b0; ins_bnd = 1'b0;
        t = exp_tgt.pop_front();
        vectors++; if (pc_tgt !== t) begin errors++; $display("FAIL blk_ret_tgt: got %h want %h", pc_tgt, t); end
        vectors++; if (jmp_cnt - j0 !== 2) begin errors++; $display("FAIL blk_jmps: got %0d want 2", jmp_cnt - j0); end
`endif
        j0 = jmp_cnt;
        reti = 1'b1;
        step();
        reti = 1'b0;
        step();
        vectors++; if (jmp_cnt !== j0) begin errors++; $display("FAIL reti_idle: got %0d want %0d", jmp_cnt, j0); end
        vectors++; if (in_isr !== 1'b0) begin errors++; $display("FAIL reti_idle_isr: got %b want 0", in_isr); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] d, e;
        logic [AW-1:0] t;
        int_vld = 1'b1; pc_i = 13'h0033;
        step();
        int_vld = 1'b0;
        reti = 1'b1;
        step();
        reti = 1'b0;
        vectors++; if (pc_jmp !== 1'b0) begin errors++; $display("FAIL reti_wait: got %b want 0", pc_jmp); end
        wr(13'h2, 16'h0000);
        vectors++; if (int_rdy !== 1'b0) begin errors++; $display("FAIL ien_off_rdy: got %b want 0", int_rdy); end
        ins_bnd = 1'b1; we = 1'b1; addr = 13'h1; din = 16'h0555;
        exp_tgt.push_back(13'h0100);
        step();
        ins_bnd = 1'b0; we = 1'b0; din = '0;
        t = exp_tgt.pop_front();
        vectors++; if (pc_jmp !== 1'b1 || pc_tgt !== t) begin
            errors++; $display("FAIL col_entry: got jmp=%b tgt=%h want jmp=1 tgt=%h", pc_jmp, pc_tgt, t);
        end
        exp_rd.push_back(16'h0033);
        rd(13'h1, d); e = exp_rd.pop_front();
        vectors++; if (d !== e) begin errors++; $display("FAIL col_epc: got %h want %h", d, e); end
        exp_rd.push_back(16'h0104);
        rd(13'h2, d); e = exp_rd.pop_front();
        vectors++; if (d !== e) begin errors++; $display("FAIL col_stat: got %h want %h", d, e); end
        reti = 1'b1; exp_tgt.push_back(13'h0033);
        step();
        reti = 1'b0;
        t = exp_tgt.pop_front();
        vectors++; if (pc_jmp !== 1'b1 || pc_tgt !== t) begin
            errors++; $display("FAIL col_ret: got jmp=%b tgt=%h want jmp=1 tgt=%h", pc_jmp, pc_tgt, t);
        end
        vectors++; if (int_rdy !== 1'b0) begin errors++; $display("FAIL col_rdy: got %b want 0", int_rdy); end
    endtask

    task automatic test_stat();
        logic [DW-1:0] d, e;
        logic [AW-1:0] t;
        wr(13'h2, 16'h0001);
        int_vld = 1'b1; pc_i = 13'h0021;
        step();
        int_vld = 1'b0;
        exp_rd.push_back(16'h0003);
        rd(13'h2, d); e = exp_rd.pop_front();
        vectors++; if (d !== e) begin errors++; $display("FAIL stat_wait: got %h want %h", d, e); end
        ins_bnd = 1'b1; exp_tgt.push_back(13'h0100);
        step();
        ins_bnd = 1'b0;
        t = exp_tgt.pop_front();
        vectors++; if (pc_tgt !== t) begin errors++; $display("FAIL stat_entry: got %h want %h", pc_tgt, t); end
        exp_rd.push_back(16'h0105);
        rd(13'h2, d); e = exp_rd.pop_front();
        vectors++; if (d !== e) begin errors++; $display("FAIL stat_act: got %h want %h", d, e); end
        exp_rd.push_back(16'h0100);
        rd(13'h0, d); e = exp_rd.pop_front();
        vectors++; if (d !== e) begin errors++; $display("FAIL rd_ivec: got %h want %h", d, e); end
        exp_rd.push_back(16'h0000);
        rd(13'h3, d); e = exp_rd.pop_front();
        vectors++; if (d !== e) begin errors++; $display("FAIL rd_unmap3: got %h want %h", d, e); end
        exp_rd.push_back(16'h0000);
        rd(13'h1fff, d); e = exp_rd.pop_front();
        vectors++; if (d !== e) begin errors++; $display("FAIL rd_unmap_top: got %h want %h", d, e); end
        reti = 1'b1; exp_tgt.push_back(13'h0021);
        step();
        reti = 1'b0;
        t = exp_tgt.pop_front();
        vectors++; if (pc_tgt !== t) begin errors++; $display("FAIL stat_ret: got %h want %h", pc_tgt, t); end
    endtask

`ifdef INT_RESP_NEST_EN
    task automatic test_nest();
        logic [DW-1:0] d, e;
        logic [AW-1:0] t;
        logic [AW-1:0] order [4];
        logic rdy_exp;
        order[0] = 13'h0014; order[1] = 13'h0012; order[2] = 13'h0011; order[3] = 13'h0010;
        wr(13'h0, 16'h0200);
        wr(13'h2, 16'h0001);
        for (int k = 0; k < 4; k++) begin
            int_vld = 1'b1; pc_i = AW'(16 + k);
            step();
            int_vld = 1'b0; ins_bnd = 1'b1; exp_tgt.push_back(13'h0200);
            step();
            ins_bnd = 1'b0;
            t = exp_tgt.pop_front();
            rdy_exp = (k < 3);
            vectors++; if (pc_tgt !== t) begin errors++; $display("FAIL nest_entry: got %h want %h", pc_tgt, t); end
            vectors++; if (int_rdy !== rdy_exp) begin errors++; $display("FAIL nest_rdy: got %b want %b", int_rdy, rdy_exp); end
        end
        int_vld = 1'b1;
        step();
        int_vld = 1'b0; ins_bnd = 1'b1;
        step();
        ins_bnd = 1'b0;
        vectors++; if (pc_jmp !== 1'b0) begin errors++; $display("FAIL nest_full: got %b want 0", pc_jmp); end
        exp_rd.push_back(16'h0405);
        rd(13'h2, d); e = exp_rd.pop_front();
        vectors++; if (d !== e) begin errors++; $display("FAIL nest_stat: got %h want %h", d, e); end
        exp_rd.push_back(16'h0013);
        rd(13'h1, d); e = exp_rd.pop_front();
        vectors++; if (d !== e) begin errors++; $display("FAIL nest_top: got %h want %h", d, e); end
        reti = 1'b1; exp_tgt.push_back(13'h0013);
        step();
        reti = 1'b0;
        t = exp_tgt.pop_front();
        vectors++; if (pc_tgt !== t) begin errors++; $display("FAIL nest_pop: got %h want %h", pc_tgt, t); end
        vectors++; if (int_rdy !== 1'b1) begin errors++; $display("FAIL nest_rdy3: got %b want 1", int_rdy); end
        int_vld = 1'b1; pc_i = 13'h0014;
        step();
        int_vld = 1'b0; ins_bnd = 1'b1;
        step();
        ins_bnd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            reti = 1'b1; exp_tgt.push_back(order[k]);
            step();
            reti = 1'b0;
            t = exp_tgt.pop_front();
            vectors++; if (pc_jmp !== 1'b1 || pc_tgt !== t) begin
                errors++; $display("FAIL nest_lifo: got jmp=%b tgt=%h want jmp=1 tgt=%h", pc_jmp, pc_tgt, t);
            end
            step();
        end
        vectors++; if (in_isr !== 1'b0) begin errors++; $display("FAIL nest_exit: got %b want 0", in_isr); end
        exp_rd.push_back(16'h0001);
        rd(13'h2, d); e = exp_rd.pop_front();
        vectors++; if (d !== e) begin errors++; $display("FAIL nest_idle_stat: got %h want %h", d, e); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [DW-1:0] d, e;
        logic [AW-1:0] t;
        int j0;
        wr(13'h0, 16'h0300);
        wr(13'h2, 16'h0001);
        int_vld = 1'b1; pc_i = 13'h0055;
        step();
        int_vld = 1'b0; ins_bnd = 1'b1; exp_tgt.push_back(13'h0300);
        step();
        ins_bnd = 1'b0;
        t = exp_tgt.pop_front();
        vectors++; if (pc_tgt !== t) begin errors++; $display("FAIL rm_entry: got %h want %h", pc_tgt, t); end
        wr(13'h1, 16'h0000);
        step();
        vectors++; if (in_isr !== 1'b1) begin errors++; $display("FAIL rm_isr: got %b want 1", in_isr); end
        j0 = jmp_cnt;
        #2 rst = 1'b1;
        #1;
        vectors++; if (in_isr !== 1'b0 || pc_tgt !== '0 || dout !== '0 || int_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rm_async: got isr=%b tgt=%h dout=%h rdy=%b want all 0", in_isr, pc_tgt, dout, int_rdy);
        end
        reti = 1'b1;
        step(); step();
        reti = 1'b0; rst = 1'b0;
        step();
        vectors++; if (jmp_cnt !== j0) begin errors++; $display("FAIL rm_nojmp: got %0d want %0d", jmp_cnt, j0); end
        exp_rd.push_back(16'h0000);
        rd(13'h0, d); e = exp_rd.pop_front();
        vectors++; if (d !== e) begin errors++; $display("FAIL rm_ivec: got %h want %h", d, e); end
        vectors++; if (in_isr !== 1'b0 || int_rdy !== 1'b0) begin
            errors++; $display("FAIL rm_state: got isr=%b rdy=%b want 0 0", in_isr, int_rdy);
        end
    endtask

    initial begin
        rst = 1'b1; din = '0; addr = '0; we = 1'b0; int_vld = 1'b0;
        ins_bnd = 1'b0; pc_i = '0; reti = 1'b0;
        test_reset();
        test_entry_exit();
        test_blocking();
        test_collision();
        test_stat();
`ifdef INT_RESP_NEST_EN
        test_nest();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
